// File: rtl/output_frame_reader.sv
// output_frame_reader: streams a frame out of output BRAM in raster order, never
// reading ahead of the writer, through a 4-entry FIFO onto a valid/ready stream.
module output_frame_reader #(
    parameter int ROWS   = 240,
    parameter int COLS   = 320,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pixel_written,
    output logic              bram_rd_en,
    output logic [16:0]       bram_rd_addr,
    input  logic [DATA_W-1:0] bram_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_user,
    output logic              m_last,
    output logic              transfer_done,
    output logic              busy
);
    localparam logic [16:0] TOTAL = 17'(ROWS * COLS);
    localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
    state_t state, state_nxt;
    logic [16:0] written_count, rd_addr, out_count;
    logic [CW-1:0] col;
    logic [DATA_W-1:0] fifo [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;
    logic rd_pend, issue, push, pop, go;
    always_comb begin
        go = state == IDLE && start;
        // occupancy plus the read in flight must leave room for this read's data
        issue = state == STREAM && rd_addr < written_count && rd_addr < TOTAL &&
                (count + {2'b0, rd_pend}) <= 3'd2;
        push = state == STREAM && rd_pend;
        m_valid = state == STREAM && count != 3'd0;
        pop = m_valid && m_ready;
        state_nxt = go ? STREAM :
                    (state == STREAM && pop && out_count == TOTAL - 17'd1) ? DONE :
                    state == DONE ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            written_count <= '0;
            rd_addr <= '0;
            out_count <= '0;
            col <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            rd_pend <= 1'b0;
            for (int i = 0; i < 4; i++) fifo[i] <= '0;
        end else begin
            state <= state_nxt;
            if (go) begin
                written_count <= {16'b0, pixel_written};
                rd_addr <= '0;
                out_count <= '0;
                col <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count <= '0;
                rd_pend <= 1'b0;
            end else begin
                if (state == STREAM && pixel_written && written_count < TOTAL)
                    written_count <= written_count + 17'd1;
                rd_pend <= issue;
                if (issue) rd_addr <= rd_addr + 17'd1;
                if (push) begin
                    fifo[wr_ptr] <= bram_rd_data;
                    wr_ptr <= wr_ptr + 2'd1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 2'd1;
                    out_count <= out_count + 17'd1;
                    col <= col == CW'(COLS - 1) ? '0 : col + CW'(1);
                end
                count <= count + {2'b0, push} - {2'b0, pop};
            end
        end
    end
    assign bram_rd_en = issue;
    assign bram_rd_addr = rd_addr;
    assign m_data = m_valid ? fifo[rd_ptr] : '0;
    assign m_user = m_valid && out_count == 17'd0;
    assign m_last = m_valid && col == CW'(COLS - 1);
    assign transfer_done = state == DONE;
    assign busy = state != IDLE;
endmodule

// File: doc/output_frame_reader.md
OUTPUT_FRAME_READER -- requirements
Module: output_frame_reader

Interface
REQ-001 Parameter ROWS, default 240, frame height in pixels.
REQ-002 Parameter COLS, default 320, frame width in pixels.
REQ-003 Parameter DATA_W, default 8, pixel width in bits.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset.
REQ-006 Port start  input  1  frame-start pulse from pipeline control (the writer IRQ).
REQ-007 Port pixel_written  input  1  one-cycle pulse per pixel committed to output BRAM by the writer.
REQ-008 Port bram_rd_en  output  1  output-BRAM read enable.
REQ-009 Port bram_rd_addr  output  17  output-BRAM read address, raster order: row*COLS+col.
REQ-010 Port bram_rd_data  input  DATA_W  read data, valid exactly one cycle after bram_rd_en.
REQ-011 Port m_valid / m_ready  output / input  1 / 1  stream handshake; transfer when both high.
REQ-012 Port m_data  output  DATA_W  pixel value.
REQ-013 Port m_user  output  1  high with pixel 0 of frame (start of frame).
REQ-014 Port m_last  output  1  high with the last pixel of each row (col == COLS-1).
REQ-015 Port transfer_done  output  1  one-cycle pulse after final pixel accepted; drives control transfer_done.
REQ-016 Port busy  output  1  high in any state other than IDLE.

Function
REQ-017 States: IDLE, STREAM, DONE; encoding free.
REQ-018 IDLE -> STREAM when start=1; clears rd_addr, out_count, written_count, FIFO.
REQ-019 start outside IDLE is ignored.
REQ-020 written_count (17 bits) increments on pixel_written in STREAM, and in IDLE on the same cycle as start (then loads 1); saturates at ROWS*COLS; pixel_written in IDLE without start, or in DONE, is ignored.
REQ-021 Read issue (bram_rd_en=1) in STREAM only when rd_addr < written_count, rd_addr < ROWS*COLS, and FIFO occupancy + in-flight reads <= 2; rd_addr increments by 1 per issue.
REQ-022 Reader never reads an address not yet written (no overrun of writer).
REQ-023 Internal output FIFO depth 4; read data captured the cycle after issue; FIFO never overflows.
REQ-024 m_valid = FIFO non-empty; m_data/m_user/m_last from FIFO head; m_data, m_user, m_last stable while m_valid=1 and m_ready=0.
REQ-025 Latency: bram_rd_en at cycle N -> corresponding m_valid no earlier than N+1, no later than N+2 with empty FIFO.
REQ-026 Throughput: with written_count ahead and m_ready held high, one pixel per cycle sustained.
REQ-027 out_count increments per accepted transfer; m_user when out_count==0; m_last when out_count mod COLS == COLS-1 (row/col counters, no divider).
REQ-028 STREAM -> DONE on the cycle the transfer with out_count == ROWS*COLS-1 is accepted.
REQ-029 DONE lasts exactly one cycle; transfer_done=1 only in DONE; DONE -> IDLE unconditionally.
REQ-030 start coincident with DONE is ignored; a new frame requires start in IDLE.
REQ-031 m_valid=0 and bram_rd_en=0 in IDLE and DONE.

Reset
REQ-032 rst=0 at any time, including mid-frame: state IDLE, all counters and FIFO cleared, in-flight read discarded.
REQ-033 Reset outputs: bram_rd_en=0, bram_rd_addr=0, m_valid=0, m_data=0, m_user=0, m_last=0, transfer_done=0, busy=0.
REQ-034 After rst release, first frame begins only on a fresh start pulse.

Verification
REQ-035 ROWS=2,COLS=4, m_ready=1, 8 pixel_written pulses back-to-back from start -> 8 beats data 0..7 in order, m_user on beat 0, m_last on beats 3 and 7, transfer_done single pulse one cycle after beat 7.
REQ-036 Writer slow: pixel_written every 5 cycles -> bram_rd_addr never >= written_count; each beat appears within 2 cycles of read issue.
REQ-037 All 8 pixels written, m_ready toggles 1,0,0,1 repeating -> no lost/duplicated pixel, m_data held stable during stalls, FIFO occupancy never exceeds 4.
REQ-038 Full frame 240x320, m_ready=1, writer one pixel/cycle -> 76800 beats, 240 m_last, one m_user, transfer_done asserted once.
REQ-039 rst asserted after beat 3 of a 2x4 frame -> all outputs reset values immediately; next start streams from pixel 0 with m_user=1.
REQ-040 start pulsed during STREAM and during DONE -> ignored; pixel_written in IDLE without start -> written_count stays 0, no read issued.
